// File: rtl/line_buffer_ctrl_if.sv
// Pixel-stream, line-buffer-feed and window handshake bundle for line_buffer_ctrl.
// master drives the stream and downstream ready; slave is the controller.
interface line_buffer_ctrl_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned CW = 10,
  parameter int unsigned RW = 10
);
  logic          start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          shift_en;
  logic [DW-1:0] bf_nxt;
  logic          win_valid;
  logic          win_ready;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          win_eol;
  logic          frame_done;

  modport master (
    output start, s_valid, s_data, win_ready,
    input  s_ready, shift_en, bf_nxt, win_valid, win_col, win_row, win_eol, frame_done
  );

  modport slave (
    input  start, s_valid, s_data, win_ready,
    output s_ready, shift_en, bf_nxt, win_valid, win_col, win_row, win_eol, frame_done
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the bicubic upscaler's line-buffer chain: prefill, stream, pad flush, drain.
// Shifts the common chain and announces each valid vertical window column.
module line_buffer_ctrl #(
  parameter int unsigned    IMG_W     = 960,
  parameter int unsigned    IMG_H     = 540,
  parameter int unsigned    NLINES    = 4,
  parameter int unsigned    PAD_ROWS  = 2,
  parameter int unsigned    DW        = 24,
  parameter logic [DW-1:0]  PAD_VALUE = '0,
  parameter int unsigned    CW        = 10,
  parameter int unsigned    RW        = 10
) (
  input logic              clk,
  input logic              rst,
  line_buffer_ctrl_if.slave bus
);

  localparam int unsigned   N_PRE        = NLINES - 1;
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] PRE_LAST_ROW = RW'(N_PRE - 1);
  localparam logic [RW-1:0] IN_LAST_ROW  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] PAD_LAST_ROW = RW'(IMG_H + PAD_ROWS - 1);
  localparam logic [RW-1:0] ROW_OFS      = RW'(N_PRE);

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StStream,
    StFlush,
    StDrain
  } state_e;

  localparam state_e AfterInput = (PAD_ROWS > 0) ? StFlush : StDrain;

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          win_valid_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          win_eol_q;
  logic          frame_done_q;

  logic          stall;
  logic          handshake;
  logic          shift;
  logic          win_shift;
  logic          s_ready;
  logic [DW-1:0] bf_nxt;
  logic          col_last;

  assign stall     = win_valid_q & ~bus.win_ready;
  assign handshake = win_valid_q & bus.win_ready;
  assign col_last  = (col_q == COL_LAST);

  // Shift and ready depend on the live win_ready so the taps freeze in the stall cycle itself.
  always_comb begin
    s_ready   = 1'b0;
    shift     = 1'b0;
    win_shift = 1'b0;
    bf_nxt    = bus.s_data;
    unique case (state_q)
      StPrefill: begin
        s_ready = 1'b1;
        shift   = bus.s_valid;
      end
      StStream: begin
        s_ready   = ~stall;
        shift     = bus.s_valid & ~stall;
        win_shift = shift;
      end
      StFlush: begin
        shift     = ~stall;
        win_shift = shift;
        bf_nxt    = PAD_VALUE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      win_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (shift) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // A window's position is the shift position relative to the first full window row.
      if (win_shift) begin
        win_valid_q <= 1'b1;
        win_col_q   <= col_q;
        win_row_q   <= row_q - ROW_OFS;
        win_eol_q   <= col_last;
      end else if (handshake) begin
        win_valid_q <= 1'b0;
        win_eol_q   <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (bus.start) begin
            col_q     <= '0;
            row_q     <= '0;
            win_col_q <= '0;
            win_row_q <= '0;
            state_q   <= (N_PRE == 0) ? StStream : StPrefill;
          end
        end
        StPrefill: begin
          if (shift && col_last && (row_q == PRE_LAST_ROW)) begin
            state_q <= (N_PRE == IMG_H) ? AfterInput : StStream;
          end
        end
        StStream: begin
          if (shift && col_last && (row_q == IN_LAST_ROW)) begin
            state_q <= AfterInput;
          end
        end
        StFlush: begin
          if (shift && col_last && (row_q == PAD_LAST_ROW)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!win_valid_q || bus.win_ready) begin
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.shift_en   = shift;
  assign bus.bf_nxt     = bf_nxt;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_eol    = win_eol_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: vector table, model-checked frames, corner sequences.
module tb_line_buffer_ctrl;

  localparam int unsigned W      = 4;
  localparam int unsigned H      = 5;
  localparam int unsigned NL     = 4;
  localparam int unsigned PR     = 2;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 3;
  localparam int unsigned RW     = 4;
  localparam int unsigned H2     = 3;
  localparam logic [DW-1:0] PAD  = 8'hEE;
  localparam int unsigned NPRE   = NL - 1;
  localparam int unsigned NOUT   = H - NL + 1 + PR;
  localparam int unsigned NWIN   = NOUT * W;
  localparam int unsigned NPIX   = H * W;
  localparam int unsigned NSHIFT = (H + PR) * W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  line_buffer_ctrl_if #(.DW(DW), .CW(CW), .RW(RW)) bus ();
  line_buffer_ctrl_if #(.DW(DW), .CW(CW), .RW(RW)) bus2 ();

  line_buffer_ctrl #(
    .IMG_W(W), .IMG_H(H), .NLINES(NL), .PAD_ROWS(PR), .DW(DW), .PAD_VALUE(PAD),
    .CW(CW), .RW(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  line_buffer_ctrl #(
    .IMG_W(W), .IMG_H(H2), .NLINES(NL), .PAD_ROWS(0), .DW(DW), .PAD_VALUE(PAD),
    .CW(CW), .RW(RW)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    check({tag, "_shift_en"}, 32'(bus.shift_en), 0);
    check({tag, "_win_valid"}, 32'(bus.win_valid), 0);
    check({tag, "_win_eol"}, 32'(bus.win_eol), 0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    check({tag, "_win_col"}, 32'(bus.win_col), 0);
    check({tag, "_win_row"}, 32'(bus.win_row), 0);
  endtask

  typedef struct {
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          win_ready;
    logic          e_s_ready;
    logic          e_shift;
    logic          e_win_valid;
    logic [DW-1:0] e_bf;
  } vec_t;

  // rdy_mode: 0 always ready, 1 toggling 1010..; abort_at: window index to reset on (-1 none).
  task automatic run_frame(input int rdy_mode, input bit sv_rand, input bit extra_start,
                           input int abort_at);
    logic [DW-1:0] exp_shift[$];
    int  ptr = 0, nsh = 0, k = 0, acc = 0, fd = 0, tail = 0;
    int  first_hs = -1, last_hs = -1, first_wv_sh = -1;
    bit  done = 1'b0;
    logic stall;
    for (int i = 0; i < int'(NPIX); i++) exp_shift.push_back(DW'(i + 1));
    for (int i = 0; i < int'(PR * W); i++) exp_shift.push_back(PAD);
    for (int c = 0; c < 400 && tail < 4; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        bus.start     = 1'b0;
        bus.s_valid   = 1'b1;
        bus.win_ready = 1'b1;
      end else begin
        bus.start     = (c == 0) || (extra_start && (nsh == 5 || nsh == int'(NPIX) + 3));
        bus.s_valid   = sv_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        bus.win_ready = (rdy_mode == 1) ? ((c % 2) == 0) : 1'b1;
      end
      bus.s_data = (ptr < int'(NPIX)) ? DW'(ptr + 1) : 8'hA5;
      @(negedge clk);
      if (done) begin
        tail++;
        check("idle_s_ready", 32'(bus.s_ready), 0);
        check("idle_shift_en", 32'(bus.shift_en), 0);
        check("idle_win_valid", 32'(bus.win_valid), 0);
        check("idle_frame_done", 32'(bus.frame_done), 0);
        continue;
      end
      stall = bus.win_valid & ~bus.win_ready;
      if (stall) check("shift_in_stall", 32'(bus.shift_en), 0);
      if (bus.win_valid && first_wv_sh < 0) first_wv_sh = nsh;
      if (bus.shift_en) begin
        check("shift_bound", 32'(nsh < int'(NSHIFT)), 1);
        if (nsh < int'(NSHIFT)) check("bf_nxt", 32'(bus.bf_nxt), 32'(exp_shift[nsh]));
        nsh++;
      end
      if (bus.s_valid && bus.s_ready) begin
        acc++;
        ptr++;
      end
      if (bus.win_valid) begin
        check("win_col", 32'(bus.win_col), k % W);
        check("win_row", 32'(bus.win_row), k / W);
        check("win_eol", 32'(bus.win_eol), 32'((k % W) == W - 1));
        if (k == abort_at) begin
          rst = 1'b1;
          #1;
          check_all_zero("abort");
          @(posedge clk);
          #1;
          rst = 1'b0;
          return;
        end
        if (bus.win_ready) begin
          if (first_hs < 0) first_hs = c;
          last_hs = c;
          k++;
        end
      end else begin
        check("win_eol_idle", 32'(bus.win_eol), 0);
      end
      if (bus.frame_done) begin
        fd++;
        check("frame_done_timing", c, last_hs + 1);
        done = 1'b1;
      end
    end
    check("frame_timeout", 32'(done), 1);
    check("frame_done_count", fd, 1);
    check("shift_count", nsh, NSHIFT);
    check("accepted_count", acc, NPIX);
    check("window_count", k, NWIN);
    check("prefill_shifts", first_wv_sh, NPRE * W + 1);
    if (rdy_mode == 0 && !sv_rand) check("burst_len", last_hs - first_hs, NWIN - 1);
  endtask

  // Configuration with no stream rows and no pad rows: prefill only, no windows.
  task automatic run_no_window_frame();
    int nsh = 0, fd = 0, last_sh = -1, wv = 0;
    for (int c = 0; c < 60 && fd == 0; c++) begin
      @(posedge clk);
      #1;
      bus2.start     = (c == 0);
      bus2.s_valid   = 1'b1;
      bus2.s_data    = DW'(nsh + 1);
      bus2.win_ready = 1'b1;
      @(negedge clk);
      if (bus2.win_valid) wv++;
      if (bus2.shift_en) begin
        check("t4_bf_nxt", 32'(bus2.bf_nxt), nsh + 1);
        nsh++;
        last_sh = c;
      end
      if (bus2.frame_done) begin
        fd++;
        check("t4_frame_done_timing", c, last_sh + 2);
      end
    end
    check("t4_frame_done_count", fd, 1);
    check("t4_shift_count", nsh, NPRE * W);
    check("t4_window_count", wv, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_idle_s_ready", 32'(bus2.s_ready), 0);
      check("t4_idle_shift_en", 32'(bus2.shift_en), 0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[1] = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12};
    vecs[2] = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 8'h13};
    vecs[3] = '{1'b0, 1'b0, 8'h14, 1'b1, 1'b1, 1'b0, 1'b0, 8'h14};
    vecs[4] = '{1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 8'h15};
    vecs[5] = '{1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16};

    rst = 1'b1;
    bus.start = 1'b0;  bus.s_valid = 1'b0;  bus.s_data = '0;  bus.win_ready = 1'b0;
    bus2.start = 1'b0; bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.win_ready = 1'b0;
    #12;
    check_all_zero("reset");
    check("reset2_s_ready", 32'(bus2.s_ready), 0);
    check("reset2_frame_done", 32'(bus2.frame_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.start     = vecs[i].start;
      bus.s_valid   = vecs[i].s_valid;
      bus.s_data    = vecs[i].s_data;
      bus.win_ready = vecs[i].win_ready;
      @(negedge clk);
      check("vec_s_ready", 32'(bus.s_ready), 32'(vecs[i].e_s_ready));
      check("vec_shift_en", 32'(bus.shift_en), 32'(vecs[i].e_shift));
      check("vec_win_valid", 32'(bus.win_valid), 32'(vecs[i].e_win_valid));
      check("vec_bf_nxt", 32'(bus.bf_nxt), 32'(vecs[i].e_bf));
    end
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("midprefill_reset_s_ready", 32'(bus.s_ready), 0);
    check("midprefill_reset_shift_en", 32'(bus.shift_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(0, 1'b0, 1'b0, -1);  // full-rate frame
    run_frame(1, 1'b0, 1'b0, -1);  // toggling downstream ready
    run_frame(0, 1'b1, 1'b0, -1);  // bursty source
    run_no_window_frame();
    run_frame(0, 1'b0, 1'b0, 6);   // reset while window (row 1, col 2) is presented
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b1, -1);  // stray start pulses in prefill and flush
    run_frame(1, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the bicubic upscaler's chain of NLINES shift-register line buffers. It accepts the input pixel stream and generates the common shift_en and the bf_nxt data feeding the first buffer. It tracks column and row position and announces when the buffer taps hold a valid vertical window. After the last input row, it flushes pad rows so the bottom border windows are produced. It sits between the pixel source (AXI-stream style) and the bicubic window/interpolation stage.

Parameters:
IMG_W, 960, pixels per line; must equal line buffer DEPTH.
IMG_H, 540, input lines per frame; must be >= NLINES-1.
NLINES, 4, line buffers in the chain (window height).
PAD_ROWS, 2, pad rows shifted in after the last input row (bottom border).
DW, 24, pixel width (RGB888).
PAD_VALUE, 0, pixel value shifted in during flush.
CW, 10, column counter width; 2^CW > IMG_W.
RW, 10, row counter width; 2^RW > IMG_H+PAD_ROWS.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  frame start pulse; honoured only in IDLE
s_valid  in  1  input pixel valid
s_data  in  DW  input pixel
s_ready  out  1  input pixel accepted when s_valid&s_ready
shift_en  out  1  shift enable to every line buffer in the chain
bf_nxt  out  DW  data into first line buffer
win_valid  out  1  line buffer taps hold a valid window column
win_ready  in  1  downstream accepts window column
win_col  out  CW  column of current window, 0..IMG_W-1
win_row  out  RW  output row of current window, 0..N_OUT_ROWS-1
win_eol  out  1  win_col==IMG_W-1 while win_valid
frame_done  out  1  one-cycle pulse after last window handshake

Behaviour:
- Reset (async, any state): state=IDLE; s_ready, shift_en, win_valid, win_eol, frame_done=0; win_col, win_row, internal col/row counters=0. Reset mid-frame abandons the frame; line buffer contents are don't-care.
- N_PRE = NLINES-1 rows. N_OUT_ROWS = IMG_H-NLINES+1+PAD_ROWS.
- stall = win_valid & ~win_ready. Line buffers never shift while stall=1, so the taps stay stable under backpressure.
- FSM states:
- IDLE: s_ready=0. On start, clear counters and go to PREFILL.
- PREFILL: s_ready=1. shift_en=s_valid. No windows are produced. After N_PRE*IMG_W accepted pixels, go to STREAM.
- STREAM: s_ready=~stall. shift_en=s_valid&~stall. After the last of IMG_H*IMG_W total accepted pixels: go to FLUSH if PAD_ROWS>0, else go to DRAIN.
- FLUSH: s_ready=0. shift_en=~stall. bf_nxt=PAD_VALUE. After PAD_ROWS*IMG_W shifts, go to DRAIN.
- DRAIN: no shifts. Wait for the final window handshake, pulse frame_done, go to IDLE.
- bf_nxt=s_data in PREFILL/STREAM; PAD_VALUE in FLUSH; s_data otherwise. shift_en is combinational from the current state and inputs.
- Window generation:
  - Each shift in STREAM or FLUSH sets win_valid=1 in the next cycle (registered).
  - win_valid clears on handshake unless a new shift occurs in the same cycle (back-to-back throughput is 1 window/clk).
  - win_col/win_row are registered with win_valid and are stable while stall=1.
- Counters: col wraps IMG_W-1 to 0 and increments row on wrap. Output row counter starts at 0 on the first STREAM window. win_eol=(win_col==IMG_W-1)&win_valid.
- The latency from shift to win_valid is 1 clk. Buffer taps are valid in that same cycle.
- start outside IDLE is ignored. s_valid in IDLE/FLUSH/DRAIN is not accepted, because s_ready=0.
- Simultaneous events:
  - A handshake and a new shift in the same cycle keeps win_valid=1 and advances col/row.
  - The last STREAM shift with win_ready=0 holds in FLUSH until stall clears.
- frame_done is asserted exactly once per frame and never together with win_valid of the next frame.

Test Plan:
1. IMG_W=4, IMG_H=5, NLINES=4, PAD_ROWS=2, s_valid and win_ready always 1, pixels 1..20 -> 12 shifts with no win_valid; then 16 windows in 16 consecutive clk, rows 0..3, cols 0..3 each; rows 2..3 fed PAD_VALUE; frame_done one clk after the 16th window; 28 shift_en cycles total.
2. Same config, win_ready toggled 1010...:
   - shift_en is never high while stall=1, and win_col/win_row stay stable during stall.
   - The window sequence is identical to test 1.
   - frame_done is still a single pulse.
3. Same config, s_valid random 50%, win_ready=1 -> exactly 20 pixels accepted, 16 windows; win_eol on col 3 only.
4. PAD_ROWS=0, IMG_H=3, IMG_W=4 -> 12 prefill shifts; 0 stream pixels; straight to DRAIN with no windows; frame_done one clk later; no FLUSH shifts.
5. Assert rst for 1 clk mid-STREAM (row 1, col 2) -> all outputs 0 in the same cycle, state IDLE; next start runs a full correct frame per test 1.
6. start pulsed during PREFILL and again during FLUSH -> ignored; counters unaffected; exactly one frame_done.
